led_blink: RTL
==============

# led_blink

Output-side counterpart to the push-button conditioner: a registered LED driver that turns a single-cycle request into a burst of N visible blinks, with programmable on and off times. It sits between synchronous control logic and an FPGA LED pin. It drives the board output, where the button conditioner cleans a board input. It reports busy/done so a controller can sequence bursts.

## Interface
- ON_TICKS, 12_500_000, clock cycles `led_o` is high per blink (≥1; 0.25 s at 50 MHz)
- OFF_TICKS, 12_500_000, clock cycles `led_o` is low after each blink (≥1)
- TMR_W, 24, phase timer width; must hold max(ON_TICKS, OFF_TICKS)−1
- CNT_W, 4, width of blink-count request
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle request; sampled on posedge clk
- num_i  in  CNT_W  blink count, sampled with `start_i`
- abort_i  in  1  cancel current burst
- busy_o  out  1  burst in progress; request ignored while high
- done_o  out  1  single-cycle pulse on normal burst completion
- led_o  out  1  LED drive, registered

## Operation
- States: IDLE, ON, OFF. Registers: state, phase timer `tmr` (TMR_W), remaining count `rem` (CNT_W), `led_o`, `done_o`.
- Reset (async, any time): state=IDLE, tmr=0, rem=0, led_o=0, busy_o=0, done_o=0.
- IDLE, start_i=1, num_i≠0, abort_i=0 → ON; rem=num_i, tmr=0, led_o=1.
- IDLE, start_i=1, num_i=0 → stay IDLE; no LED activity, no done_o.
- ON: tmr increments each cycle. When tmr==ON_TICKS−1 → OFF, tmr=0, led_o=0.
- OFF: tmr increments each cycle. When tmr==OFF_TICKS−1:
  - If rem==1 → IDLE, done_o=1 for one cycle.
  - Else → ON, rem=rem−1, tmr=0, led_o=1.
- start_i while busy_o=1 is ignored. No queuing, no error flag.
- abort_i=1 in ON or OFF → IDLE next edge, led_o=0, tmr=0, rem=0, no done_o.
- abort_i has priority over start_i and over the normal phase transition in the same cycle.
- busy_o = (state≠IDLE), decoded from the state register only.
- Arithmetic: tmr compares are equality only, with no wrap past the terminal value. rem never decrements below 1. num_i max value (2^CNT_W−1) is legal.

## Timing
- Request latency: start_i sampled at edge E0 → led_o, busy_o high immediately after E0.
- Each blink: led_o high exactly ON_TICKS cycles, then low exactly OFF_TICKS cycles.
- busy_o is high for exactly num_i×(ON_TICKS+OFF_TICKS) cycles.
- done_o rises on the same edge busy_o falls and lasts one cycle.
- start_i in the done_o cycle is accepted, giving back-to-back bursts with no dead cycle.
- Abort latency: one edge. led_o is low, busy_o is low after that edge.
- Reset mid-burst: outputs go to reset values asynchronously. The first request after rst deasserts behaves as from power-up.

## Structure
- Shared package `led_pkg`: state encoding constants (IDLE/ON/OFF, 2-bit). This is the common encoding for LED/indicator blocks.
- One sub-module is natural: `phase_timer` (TMR_W counter with clear, enable, and terminal-count compare against a runtime limit). It is reusable by the button conditioner's saturating counter.
- Remainder of the block: FSM and rem/led_o/done_o registers in `led_blink`.

## Test plan
Bench parameters: ON_TICKS=3, OFF_TICKS=2, CNT_W=4.
- Single burst: start_i with num_i=2 → led_o pattern 1,1,1,0,0,1,1,1,0,0. busy_o high for 10 cycles. done_o pulse on cycle 11 with busy_o=0.
- Zero/ignored requests:
  - num_i=0 → no change on any output.
  - start_i (num_i=5) issued mid-burst of num_i=1 → exactly 1 blink and 1 done_o.
- Back-to-back: start_i(num_i=1) in the done_o cycle → new led_o rise on the next cycle. Total 2 blinks, 2 done_o pulses, no gap cycle.
- Abort: num_i=3, abort_i at cycle 4 (OFF phase) → led_o=0, busy_o=0 next cycle, no done_o. Simultaneous start_i+abort_i in IDLE → stays IDLE.
- Reset: assert rst asynchronously mid-ON with led_o=1 → led_o, busy_o, done_o = 0 before the next clk edge. After release, num_i=15 runs 15 blinks (75 cycles busy).

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared encoding for LED and indicator blocks.
//
// Contents:
//   led_state_e - 2-bit state encoding (IDLE / ON / OFF) used by
//                 led_blink and any sibling indicator driver, so the
//                 debug state buses decode the same way everywhere.
package led_pkg;

  localparam int unsigned LED_STATE_W = 2;

  typedef enum logic [LED_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } led_state_e;

endpackage : led_pkg

// File: rtl/led_blink_phase_timer.sv
// phase_timer: up-counter with synchronous clear, count enable and a
// terminal-count compare against a limit supplied at run time.
//
// Ports:
//   clk   - clock, all updates on posedge
//   rst   - asynchronous active-high reset, forces cnt to 0
//   clr   - synchronous clear (wins over en)
//   en    - increment enable
//   limit - terminal value; tc is high while cnt == limit
//   cnt   - current count
//   tc    - terminal-count flag (combinational compare of registered cnt)
//
// The compare is equality only: the owner is expected to clear the
// counter on tc, so cnt never wraps past the terminal value.
module phase_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == limit);

endmodule : phase_timer

// File: rtl/led_blink.sv
// led_blink: registered LED driver that turns a one-cycle request into a
// burst of num_i blinks, each ON_TICKS cycles high then OFF_TICKS low.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   start_i   - one-cycle burst request, sampled on posedge clk
//   num_i     - blink count, sampled with start_i (0 means no burst)
//   abort_i   - cancel the running burst (no done_o)
//   busy_o    - burst in progress, decoded from the state register
//   done_o    - one-cycle pulse on normal burst completion
//   led_o     - registered LED drive
//   state_dbg - current FSM state for observation
//
// Request handshake: start_i acts as a valid and ~busy_o as the ready.
// A request is taken on a rising edge where start_i=1, busy_o=0,
// abort_i=0 and num_i!=0; any other request is dropped without trace
// (no queuing, no error). Because done_o is raised on the same edge that
// busy_o falls, a request presented during the done_o cycle is accepted
// and bursts can run back to back with no dead cycle.
module led_blink
  import led_pkg::*;
#(
  parameter int unsigned ON_TICKS  = 12_500_000,
  parameter int unsigned OFF_TICKS = 12_500_000,
  parameter int unsigned TMR_W     = 24,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             led_o,
  output led_state_e       state_dbg
);

  // Terminal values of the phase timer; each phase lasts limit+1 cycles.
  localparam logic [TMR_W-1:0] ON_LIM  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LIM = TMR_W'(OFF_TICKS - 1);

  led_state_e       state;
  logic [CNT_W-1:0] rem;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_limit;
  logic             tmr_tc;
  logic             tmr_clr;
  logic             tmr_en;

  // The timer runs only inside a burst. It is held at zero in IDLE so a
  // new burst always starts its first ON phase from tmr=0, and it is
  // cleared on every phase change and on abort.
  assign tmr_limit = (state == ST_OFF) ? OFF_LIM : ON_LIM;
  assign tmr_en    = (state != ST_IDLE);
  assign tmr_clr   = (state == ST_IDLE) || abort_i || tmr_tc;

  phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .cnt   (tmr),
    .tc    (tmr_tc)
  );

  // tc is only meaningful while a burst is running; in IDLE the timer
  // sits at 0 and the FSM ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rem    <= '0;
      led_o  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !abort_i && (num_i != '0)) begin
            state <= ST_ON;
            rem   <= num_i;
            led_o <= 1'b1;
          end
        end

        ST_ON: begin
          if (abort_i) begin
            state <= ST_IDLE;
            rem   <= '0;
            led_o <= 1'b0;
          end else if (tmr_tc) begin
            state <= ST_OFF;
            led_o <= 1'b0;
          end
        end

        ST_OFF: begin
          if (abort_i) begin
            state <= ST_IDLE;
            rem   <= '0;
            led_o <= 1'b0;
          end else if (tmr_tc) begin
            if (rem == CNT_W'(1)) begin
              // Last blink finished: leave rem at 1 (never below), the
              // next accepted request reloads it.
              state  <= ST_IDLE;
              done_o <= 1'b1;
            end else begin
              state <= ST_ON;
              rem   <= rem - CNT_W'(1);
              led_o <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          rem   <= '0;
          led_o <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = (state != ST_IDLE);
  assign state_dbg = state;

endmodule : led_blink
